// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a line-refill FSM. Lookup is combinational;
// a miss fetches a whole line in order, starting at word 0, over a hold-until-ready read port.
module icache_fill_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int OFF_BITS   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        i_hit,
  output logic [15:0] instr,
  output logic        mem_re,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdy
);

  // state | meaning
  // IDLE  | lookups served; a miss starts a line refill
  // FILL  | line refill in progress; i_hit held low
  typedef enum logic {IDLE, FILL} state_t;

  localparam int TAG_BITS = 16 - INDEX_BITS - OFF_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFF_BITS;

  state_t state, state_nxt;

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [15:0]           data_mem [LINES][WORDS];

  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] pc_index;
  logic [OFF_BITS-1:0]   pc_off;
  logic                  lookup_hit;

  logic [TAG_BITS-1:0]   fill_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [OFF_BITS-1:0]   fill_cnt;

  logic fill_start;
  logic word_we;
  logic line_done;

  assign pc_tag   = pc[15 -: TAG_BITS];
  assign pc_index = pc[OFF_BITS +: INDEX_BITS];
  assign pc_off   = pc[OFF_BITS-1:0];

  assign lookup_hit = valid[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign i_hit      = fetch_en && (state == IDLE) && !flush && lookup_hit;
  assign instr      = i_hit ? data_mem[pc_index][pc_off] : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // flush outranks both miss detection and line completion
  always_comb begin
    state_nxt  = state;
    fill_start = 1'b0;
    word_we    = 1'b0;
    line_done  = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && fetch_en && !lookup_hit) begin
          fill_start = 1'b1;
          state_nxt  = FILL;
        end
      end
      FILL: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (mem_rdy) begin
          word_we = 1'b1;
          if (&fill_cnt) begin
            line_done = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= '0;
      mem_re     <= 1'b0;
      mem_addr   <= 16'h0000;
      fill_cnt   <= '0;
      fill_tag   <= '0;
      fill_index <= '0;
    end else begin
      if (flush)          valid             <= '0;
      else if (line_done) valid[fill_index] <= 1'b1;

      if (fill_start) begin
        fill_tag   <= pc_tag;
        fill_index <= pc_index;
        fill_cnt   <= '0;
        mem_re     <= 1'b1;
        mem_addr   <= {pc_tag, pc_index, {OFF_BITS{1'b0}}};
      end else if (state == FILL) begin
        if (flush || line_done) begin
          mem_re <= 1'b0;
        end else if (word_we) begin
          // offset field wraps inside the line; never carries into the index
          fill_cnt <= fill_cnt + 1'b1;
          mem_addr <= {fill_tag, fill_index, fill_cnt + 1'b1};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_we)   data_mem[fill_index][fill_cnt] <= mem_rdata;
    if (line_done) tag_mem[fill_index]            <= fill_tag;
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: a line-level cache model checked every cycle,
// plus hand-computed expectations for each scenario. Memory returns addr ^ 16'hA500.
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        fetch_en;
  logic        flush;
  logic        i_hit;
  logic [15:0] instr;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rdy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdy_mode = 0;

  icache_fill_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .fetch_en  (fetch_en),
    .flush     (flush),
    .i_hit     (i_hit),
    .instr     (instr),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ 16'hA500;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Line-level model: valid/tag per line, plus the address of the line being fetched
  // and how many of its words memory has delivered so far.
  bit          m_valid [16];
  logic [9:0]  m_tag   [16];
  bit          m_busy;
  logic [15:0] m_base;
  int          m_acked;

  always @(negedge clk) begin
    logic exp_hit;
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_acked = 0;
      foreach (m_valid[k]) m_valid[k] = 1'b0;
    end
    exp_hit = fetch_en && !m_busy && !flush && m_valid[pc[5:2]] && (m_tag[pc[5:2]] == pc[15:6]);
    chk("cmp_hit",   {15'd0, i_hit},  {15'd0, exp_hit});
    chk("cmp_instr", instr, exp_hit ? (pc ^ 16'hA500) : 16'h0000);
    chk("cmp_re",    {15'd0, mem_re}, {15'd0, m_busy});
    if (m_busy)  chk("cmp_addr", mem_addr, m_base + 16'(m_acked));
    if (!rst_n)  chk("cmp_rst_addr", mem_addr, 16'h0000);
    if (rst_n) begin
      if (flush) begin
        foreach (m_valid[k]) m_valid[k] = 1'b0;
        m_busy = 1'b0;
      end else if (m_busy) begin
        if (mem_rdy) begin
          m_acked++;
          if (m_acked == 4) begin
            m_busy = 1'b0;
            m_valid[m_base[5:2]] = 1'b1;
            m_tag[m_base[5:2]]   = m_base[15:6];
          end
        end
      end else if (fetch_en && !exp_hit) begin
        m_busy  = 1'b1;
        m_base  = {pc[15:2], 2'b00};
        m_acked = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mem_rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
  endtask

  task automatic wait_hit(input string nm, input int limit);
    for (int k = 0; k < limit; k++) begin
      tick();
      #1;
      if (i_hit) break;
    end
    chk(nm, {15'd0, i_hit}, 16'd1);
  endtask

  logic [15:0] addr_q[$];

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; pc = 16'h0000; flush = 1'b0; mem_rdy = 1'b0;
    repeat (3) tick();
    chk("rst_mem_re",   {15'd0, mem_re}, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_i_hit",    {15'd0, i_hit}, 16'd0);

    // cold fetch: miss in cycle 0, words 0040..0043 requested, hit in cycle 5
    rst_n = 1'b1; fetch_en = 1'b1; pc = 16'h0040; mem_rdy = 1'b1;
    #1;
    chk("cold_c0_hit",   {15'd0, i_hit}, 16'd0);
    chk("cold_c0_instr", instr, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cold_re",   {15'd0, mem_re}, 16'd1);
      chk("cold_addr", mem_addr, 16'h0040 + 16'(i));
      chk("cold_nohit", {15'd0, i_hit}, 16'd0);
    end
    tick();
    chk("cold_c5_hit",   {15'd0, i_hit}, 16'd1);
    chk("cold_c5_instr", instr, 16'hA540);

    // hits on the rest of the line
    for (int i = 1; i < 4; i++) begin
      pc = 16'h0040 + 16'(i);
      #1;
      chk("line_hit",   {15'd0, i_hit}, 16'd1);
      chk("line_instr", instr, 16'hA540 + 16'(i));
      chk("line_no_re", {15'd0, mem_re}, 16'd0);
      tick();
    end

    // stalling memory: ack only every third cycle
    rdy_mode = 1; pc = 16'h1234;
    addr_q.delete();
    for (int k = 0; k < 40; k++) begin
      tick();
      #1;
      if (mem_re && (addr_q.size() == 0 || addr_q[$] != mem_addr)) addr_q.push_back(mem_addr);
      if (i_hit) break;
    end
    chk("stall_done",  {15'd0, i_hit}, 16'd1);
    chk("stall_instr", instr, 16'hB734);
    chk("stall_naddr", 16'(addr_q.size()), 16'd4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++) chk("stall_seq", addr_q[i], 16'h1234 + 16'(i));
    pc = 16'h1237;
    #1;
    chk("stall_w3", instr, 16'hB737);
    rdy_mode = 0; mem_rdy = 1'b1;

    // conflict: same index, different tag evicts 0040
    pc = 16'h0440;
    #1;
    chk("conf_miss", {15'd0, i_hit}, 16'd0);
    wait_hit("conf_fill", 20);
    chk("conf_instr", instr, 16'hA140);
    tick();
    pc = 16'h0040;
    #1;
    chk("conf_evicted", {15'd0, i_hit}, 16'd0);
    wait_hit("conf_refill", 20);
    chk("conf_re_instr", instr, 16'hA540);

    // wrap: mid-line miss fetches from word 0 of its own line
    tick();
    pc = 16'h003E;
    tick();
    chk("wrap_addr0", mem_addr, 16'h003C);
    wait_hit("wrap_fill", 20);
    chk("wrap_instr", instr, 16'hA53E);

    // flush after the second word is acked
    tick();
    pc = 16'h0080;
    #1;
    chk("fl_miss", {15'd0, i_hit}, 16'd0);
    tick(); tick(); tick();
    chk("fl_addr2", mem_addr, 16'h0082);
    flush = 1'b1;
    #1;
    chk("fl_hit_low", {15'd0, i_hit}, 16'd0);
    tick();
    flush = 1'b0;
    chk("fl_re_low", {15'd0, mem_re}, 16'd0);
    tick();
    chk("fl_restart_re",   {15'd0, mem_re}, 16'd1);
    chk("fl_restart_addr", mem_addr, 16'h0080);
    wait_hit("fl_refill", 20);
    chk("fl_instr", instr, 16'hA580);

    // flush while holding hit lines
    tick();
    pc = 16'h0041;
    wait_hit("fl2_fill", 20);
    flush = 1'b1;
    #1;
    chk("fl2_forced", {15'd0, i_hit}, 16'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl2_miss", {15'd0, i_hit}, 16'd0);
    tick();
    chk("fl2_addr", mem_addr, 16'h0040);
    wait_hit("fl2_refill", 20);

    // fetch_en low on a resident line: no hit, no request
    tick();
    fetch_en = 1'b0;
    #1;
    chk("fe0_hit",   {15'd0, i_hit}, 16'd0);
    chk("fe0_instr", instr, 16'h0000);
    repeat (3) tick();
    chk("fe0_no_re", {15'd0, mem_re}, 16'd0);

    // reset during a fill
    fetch_en = 1'b1; pc = 16'h2000;
    tick();
    chk("rf_re", {15'd0, mem_re}, 16'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rf_re_low", {15'd0, mem_re}, 16'd0);
    chk("rf_addr",   mem_addr, 16'h0000);
    fetch_en = 1'b0;
    tick();
    rst_n = 1'b1; fetch_en = 1'b1; pc = 16'h0040;
    #1;
    chk("rf_cold", {15'd0, i_hit}, 16'd0);
    wait_hit("rf_refill", 20);
    tick();
    fetch_en = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Direct-mapped instruction cache and refill controller; the responder to the IF stage's fetch request.
- Supplies the i_hit and instr signals that the IF-stage instruction select consumes; a NOP (16'h0000) is injected whenever i_hit is low.
- On a miss, refills one whole line from main memory over a hold-until-ready read handshake, then reports a hit.

Parameters:
- INDEX_BITS, 4, number of line-index bits (16 lines).
- OFF_BITS, 2, word-offset bits (4 words of 16 bits per line).
- Tag width is derived as 16-INDEX_BITS-OFF_BITS (10 with defaults).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc  input  16  word address of the requested instruction.
- fetch_en  input  1  fetch request valid (low in non-fetch mode).
- flush  input  1  invalidate all lines.
- i_hit  output  1  instr is valid this cycle.
- instr  output  16  instruction word; 16'h0000 when i_hit=0.
- mem_re  output  1  memory read request.
- mem_addr  output  16  memory word address.
- mem_rdata  input  16  memory read data, valid when mem_rdy=1.
- mem_rdy  input  1  memory read-data acknowledge.

Behaviour:
- Storage: per line, a valid bit, a tag, and 2^OFF_BITS data words. Address split is pc = {tag, index, offset}.
- Reset (async, rst_n=0): all valid bits 0, state IDLE, mem_re=0, mem_addr=0, fill counter 0. i_hit=0 and instr=0 follow combinationally. Data and tag arrays are not reset.
- Lookup is combinational, with zero latency:
  - i_hit = fetch_en & state==IDLE & valid[index] & tag[index]==pc tag.
  - instr = data[index][offset] when i_hit=1, else 16'h0000.
- FSM, two states: IDLE and FILL.
  - IDLE: if fetch_en, no hit, and flush=0, then at the next edge latch the miss tag and index, clear the fill counter, set mem_re=1 and mem_addr={tag,index,0}, and go to FILL.
  - IDLE with fetch_en=0: no action.
  - FILL: mem_re and mem_addr are held stable until mem_rdy=1 is sampled.
  - On each sampled mem_rdy: write mem_rdata into data[latched index][counter] and increment the counter.
    - If it was not the last word, mem_addr advances to the next word and mem_re stays 1 with no bubble.
    - On the last word: set valid=1 and write the tag for the latched index, drive mem_re=0, go to IDLE.
  - i_hit=0 for the whole of FILL, regardless of pc.
- Refill order: word 0 first (no critical-word-first); words are filled strictly in order.
- pc or fetch_en changing during FILL has no effect; the latched line completes.
- Memory handshake:
  - mem_rdy may be high in the same cycle that mem_re first rises (1-cycle memory).
  - mem_rdy is ignored while mem_re=0.
  - mem_re and mem_addr are registered outputs.
- Latency: miss seen in cycle T; with mem_rdy tied high, words are captured at the edges ending T+1..T+4, and i_hit=1 in cycle T+5 (5-cycle miss penalty). Each stall cycle on mem_rdy adds one cycle.
- flush:
  - Clears all valid bits at the next edge and forces i_hit=0 in the same cycle.
  - In FILL: the fill is aborted, state goes to IDLE, mem_re=0 from the next cycle, and the partially filled line stays invalid. A mem_rdy coincident with flush is dropped.
  - flush has priority over miss detection and over line completion.
- Reset mid-FILL: immediate return to reset values; any data in flight is discarded.
- Wrap-around: mem_addr offset bits count 0..2^OFF_BITS-1 and never carry into the index bits.
- Conflict: a miss to an index holding a different tag overwrites that line; there is no write-back (instruction memory is read-only).

Test Plan:
- Reset then cold fetch: rst_n=0→1, fetch_en=1, pc=16'h0040, mem_rdy=1. Required: i_hit=0 and instr=16'h0000 in cycle 0; mem_re=1 with mem_addr 0040,0041,0042,0043 on consecutive cycles; i_hit=1 in cycle 5 with instr = word returned for 0040.
- Hits after fill: pc=0041, 0042, 0043 on consecutive cycles. Required: i_hit=1 every cycle, instr matches memory, mem_re=0 throughout.
- Stalling memory: miss at pc=16'h1234, mem_rdy high only every 3rd cycle. Required: mem_addr holds each of 1234..1237 until acked; valid is set only after the 4th ack; data is correct.
- Conflict: fill 16'h0040, then fetch 16'h0440 (same index, different tag). Required: miss and refill of 0440..0443; a subsequent fetch of 0040 misses again.
- Flush mid-fill: assert flush after the 2nd word is acked. Required: mem_re=0 next cycle, state IDLE, and re-fetching the same pc restarts the fill at word 0. Also: flush while holding hit lines forces the next fetch of 0041 to miss.
- fetch_en=0 with a valid-line pc: required i_hit=0, instr=0000, and no memory request issued. Separately, asserting rst_n=0 during FILL must give mem_re=0 immediately.
